comb_bank_sched: RTL

Time-multiplexed scheduler that runs a bank of parallel feedback comb lines, the core of a Schroeder-style reverb, over one shared single-port delay RAM. For each incoming audio sample it sequences a read, feedback computation and write-back for every channel in turn. It advances per-channel circular pointers and emits the averaged comb output. It sits between the sample source and the downstream all-pass/output stage, and replaces N independent per-line memories with one RAM.

---
 rtl/comb_pkg.sv | 46 ++++
 rtl/comb_delay_ram.sv | 26 ++
 rtl/comb_bank_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/comb_pkg.sv
// Shared constants, types and helpers for the time-multiplexed comb bank.
// BASE of each comb line is the prefix sum of the lengths before it.
package comb_pkg;

  localparam int N_CH        = 4;
  localparam int DW          = 32;
  localparam int DEPTH_TOTAL = 8192;

  localparam int COMB_LEN [N_CH] = '{1557, 1617, 1491, 1422};

  // Start word of comb line ch inside the shared RAM.
  function automatic int comb_base(input int ch);
    int sum;
    sum = 0;
    for (int i = 0; i < ch; i++) begin
      sum += COMB_LEN[i];
    end
    return sum;
  endfunction

  // Longest comb line; sets the circular pointer width.
  function automatic int comb_max_len();
    int mx;
    mx = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (COMB_LEN[i] > mx) mx = COMB_LEN[i];
    end
    return mx;
  endfunction

  localparam int AW  = $clog2(DEPTH_TOTAL);
  localparam int PW  = $clog2(comb_max_len());
  localparam int CHW = $clog2(N_CH);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    RD    = 3'd2,
    WAIT  = 3'd3,
    WR    = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef logic signed [DW-1:0] sample_t;

endpackage

// File: rtl/comb_delay_ram.sv
// Single-port synchronous RAM holding every comb delay line; read-first,
// one-cycle read latency, no reset so it maps onto block RAM.
module comb_delay_ram
  import comb_pkg::*;
#(
  parameter int DEPTH = DEPTH_TOTAL,
  parameter int WIDTH = DW
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write and registered read on the single port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/comb_bank_sched.sv
// Runs N_CH feedback comb lines per input sample over one shared RAM:
// read, wait, write-back per channel, then emits the averaged comb output.
module comb_bank_sched
  import comb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_in,
  output logic                 busy,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_sample,
  output logic                 overrun
);

  localparam logic [AW-1:0]  CLR_LAST = AW'(DEPTH_TOTAL - 1);
  localparam logic [AW-1:0]  ADDR_ONE = AW'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [CHW-1:0] CH_ONE   = CHW'(1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(N_CH - 1);

  state_t         state_r, state_next;
  logic [AW-1:0]  clr_addr_r;
  logic [PW-1:0]  ptr_r [N_CH];
  logic [CHW-1:0] ch_r;
  sample_t        x_r, acc_r, out_sample_r;
  logic           out_valid_r, overrun_r, busy_r;

  logic           ram_we_s;
  logic [AW-1:0]  ram_addr_s, cur_addr_s;
  sample_t        ram_wdata_s, ram_rdata_s, fb_s, acc_next_s;

  logic [AW-1:0]  base_tbl [N_CH];
  logic [PW-1:0]  last_tbl [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_tbl
    assign base_tbl[g] = AW'(comb_base(g));
    assign last_tbl[g] = PW'(COMB_LEN[g] - 1);
  end

  // Feedback of 0.875 built from truncating shifts; output averages the taps.
  assign cur_addr_s = base_tbl[ch_r] + AW'(ptr_r[ch_r]);
  assign fb_s       = (x_r >>> 1'd1) + (ram_rdata_s >>> 1'd1)
                    + (ram_rdata_s >>> 2'd2) + (ram_rdata_s >>> 2'd3);
  assign acc_next_s = acc_r + (ram_rdata_s >>> CHW);

  comb_delay_ram #(
    .DEPTH (DEPTH_TOTAL),
    .WIDTH (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CLEAR;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state and RAM port control.
  always_comb begin
    state_next  = state_r;
    ram_we_s    = 1'b0;
    ram_addr_s  = cur_addr_s;
    ram_wdata_s = fb_s;
    case (state_r)
      CLEAR: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = clr_addr_r;
        ram_wdata_s = {DW{1'b0}};
        if (clr_addr_r == CLR_LAST) state_next = IDLE;
        else                        state_next = CLEAR;
      end
      IDLE: begin
        if (sample_valid && enable) state_next = RD;
        else                        state_next = IDLE;
      end
      RD:   state_next = WAIT;
      WAIT: state_next = WR;
      WR: begin
        ram_we_s = 1'b1;
        if (ch_r == CH_LAST) state_next = DONE;
        else                 state_next = RD;
      end
      DONE:    state_next = IDLE;
      default: state_next = CLEAR;
    endcase
  end

  // Datapath: clear counter, pointers, accumulator and registered outputs.
  // The result is registered on the last write so out_valid lines up with DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr_r   <= {AW{1'b0}};
      ch_r         <= {CHW{1'b0}};
      x_r          <= {DW{1'b0}};
      acc_r        <= {DW{1'b0}};
      out_sample_r <= {DW{1'b0}};
      out_valid_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b1;
      for (int i = 0; i < N_CH; i++) ptr_r[i] <= {PW{1'b0}};
    end else begin
      out_valid_r <= 1'b0;
      overrun_r   <= sample_valid && (state_r != IDLE);
      busy_r      <= (state_next != IDLE);
      case (state_r)
        CLEAR: begin
          clr_addr_r <= (state_next == IDLE) ? {AW{1'b0}} : clr_addr_r + ADDR_ONE;
        end
        IDLE: begin
          if (sample_valid) begin
            if (enable) begin
              x_r   <= sample_in;
              acc_r <= {DW{1'b0}};
              ch_r  <= {CHW{1'b0}};
            end else begin
              out_sample_r <= sample_in;
              out_valid_r  <= 1'b1;
              for (int i = 0; i < N_CH; i++) ptr_r[i] <= {PW{1'b0}};
            end
          end
        end
        WR: begin
          acc_r <= acc_next_s;
          if (ptr_r[ch_r] == last_tbl[ch_r]) ptr_r[ch_r] <= {PW{1'b0}};
          else                               ptr_r[ch_r] <= ptr_r[ch_r] + PTR_ONE;
          if (ch_r == CH_LAST) begin
            out_sample_r <= acc_next_s;
            out_valid_r  <= 1'b1;
          end else begin
            ch_r <= ch_r + CH_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign out_valid  = out_valid_r;
  assign out_sample = out_sample_r;
  assign overrun    = overrun_r;

endmodule
